divider_nonperforming_configurable: RTL

DIVIDER_NONPERFORMING_CONFIGURABLE -- requirements
Module: divider_nonperforming_configurable

---
 rtl/divider_pkg.sv | 15 +
 rtl/divider_nonperforming_step.sv | 25 ++
 rtl/divider_nonperforming_configurable.sv | 134 +++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and result status flags.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic error;
    logic overflow;
  } status_t;

endpackage

// File: rtl/divider_nonperforming_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor,
// keep the difference only when it did not borrow.
module divider_nonperforming_step #(
  parameter int DEN_BITS = 16
) (
  input  logic [DEN_BITS:0]   rem_i,
  input  logic                bit_i,
  input  logic [DEN_BITS-1:0] den_i,
  output logic [DEN_BITS:0]   rem_o,
  output logic                qbit_o
);

  logic [DEN_BITS+1:0] shifted;
  logic [DEN_BITS+1:0] diff;

  // The incoming partial remainder is always below the divisor, so its top bit is zero
  // and the extra MSB of diff is a clean borrow indicator.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, den_i};
    qbit_o  = ~diff[DEN_BITS+1];
    rem_o   = qbit_o ? diff[DEN_BITS:0] : shifted[DEN_BITS:0];
  end

endmodule

// File: rtl/divider_nonperforming_configurable.sv
// Sequential signed/unsigned restoring divider, one quotient bit per enabled cycle;
// result valid NUM_BITS+1 enabled cycles after accept and held until out_ready.
module divider_nonperforming_configurable
  import divider_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int DEN_BITS = 16
) (
  input  logic                tb_clk,
  input  logic                tb_srst,
  input  logic                ce,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                signed_mode,
  input  logic [NUM_BITS-1:0] numerator,
  input  logic [DEN_BITS-1:0] denominator,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] quotient,
  output logic [DEN_BITS-1:0] remainder,
  output logic                error,
  output logic                overflow
);

  localparam int               CNT_W     = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_BITS);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DEN_BITS:0]   rem_q;
  logic [DEN_BITS:0]   rem_d;
  logic [NUM_BITS-1:0] dvd_q;
  logic [NUM_BITS-1:0] dvd_d;
  logic [DEN_BITS-1:0] den_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic                ovf_q;
  logic [NUM_BITS-1:0] quot_q;
  logic [DEN_BITS-1:0] rmd_q;
  status_t             status_q;

  logic                qbit;
  logic                num_neg;
  logic                den_neg;
  logic                den_zero;
  logic                ovf_case;
  logic [NUM_BITS-1:0] num_abs;
  logic [DEN_BITS-1:0] den_abs;

  assign num_neg  = signed_mode & numerator[NUM_BITS-1];
  assign den_neg  = signed_mode & denominator[DEN_BITS-1];
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign num_abs  = num_neg ? -numerator : numerator;
  assign den_abs  = den_neg ? -denominator : denominator;
  assign den_zero = (denominator == '0);
  assign ovf_case = signed_mode && (numerator == {1'b1, {(NUM_BITS-1){1'b0}}})
                    && (denominator == '1);

  assign in_ready  = (state_q == IDLE) & ce;
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign error     = status_q.error;
  assign overflow  = status_q.overflow;

  // The dividend register doubles as the quotient register: bits shift out at the top
  // while quotient bits shift in at the bottom.
  assign dvd_d = {dvd_q[NUM_BITS-2:0], qbit};

  divider_nonperforming_step #(
    .DEN_BITS(DEN_BITS)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[NUM_BITS-1]),
    .den_i (den_q),
    .rem_o (rem_d),
    .qbit_o(qbit)
  );

  always_ff @(posedge tb_clk or negedge tb_srst) begin
    if (!tb_srst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      den_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ovf_q    <= 1'b0;
      quot_q   <= '0;
      rmd_q    <= '0;
      status_q <= '0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (den_zero) begin
              state_q  <= DONE;
              quot_q   <= '1;
              rmd_q    <= '0;
              status_q <= '{error: 1'b1, overflow: 1'b0};
            end else begin
              state_q <= CALC;
              cnt_q   <= '0;
              rem_q   <= '0;
              dvd_q   <= num_abs;
              den_q   <= den_abs;
              q_neg_q <= num_neg ^ den_neg;
              r_neg_q <= num_neg;
              ovf_q   <= ovf_case;
            end
          end
        end
        CALC: begin
          if (cnt_q == LAST_ITER) begin
            state_q  <= DONE;
            quot_q   <= q_neg_q ? -dvd_q : dvd_q;
            rmd_q    <= r_neg_q ? -rem_q[DEN_BITS-1:0] : rem_q[DEN_BITS-1:0];
            status_q <= '{error: 1'b0, overflow: ovf_q};
          end else begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
